// File: rtl/csr_pkg.sv
// csr_pkg
// Shared definitions for the machine-mode CSR unit: CSR addresses,
// the Zicsr operation encoding, the bit positions of the architected
// fields inside mstatus/mie/mip, and the interrupt cause codes.
package csr_pkg;

    // Implemented CSR addresses
    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MIE     = 12'h304;
    localparam logic [11:0] ADDR_MTVEC   = 12'h305;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
    localparam logic [11:0] ADDR_MIP     = 12'h344;
    localparam logic [11:0] ADDR_MCYCLE  = 12'hB00;
    localparam logic [11:0] ADDR_MCYCLEH = 12'hB80;

    // Zicsr operation carried with the instruction in MW
    typedef enum logic [1:0] {
        CSR_NONE  = 2'b00,
        CSR_WRITE = 2'b01,
        CSR_SET   = 2'b10,
        CSR_CLEAR = 2'b11
    } csr_op_e;

    // mstatus fields
    localparam int MSTATUS_MIE_BIT  = 3;
    localparam int MSTATUS_MPIE_BIT = 7;
    localparam int MSTATUS_MPP_LO   = 11;

    // mie / mip fields share positions
    localparam int MIE_MTIE_BIT = 7;
    localparam int MIE_MEIE_BIT = 11;
    localparam int MIP_MTIP_BIT = 7;
    localparam int MIP_MEIP_BIT = 11;

    // Interrupt cause codes (mcause low bits)
    localparam logic [3:0] CAUSE_MTI = 4'd7;
    localparam logic [3:0] CAUSE_MEI = 4'd11;

endpackage

// File: rtl/csr_trap_ctrl.sv
// csr_trap_ctrl
// Combinational interrupt acceptance and redirect target computation.
// Ports:
//   global_ie  - mstatus.MIE
//   mtie/meie  - mie enables for timer/external interrupts
//   timer_irq  - live MTIP line
//   ext_irq    - live MEIP line
//   is_mret    - MRET in MW, masks interrupts for this cycle
//   mtvec      - current mtvec (base + mode)
//   trap_taken - interrupt accepted this cycle
//   cause      - accepted cause code (external wins over timer)
//   trap_pc    - redirect target
module csr_trap_ctrl
    import csr_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            global_ie,
    input  logic            mtie,
    input  logic            meie,
    input  logic            timer_irq,
    input  logic            ext_irq,
    input  logic            is_mret,
    input  logic [XLEN-1:0] mtvec,
    output logic            trap_taken,
    output logic [3:0]      cause,
    output logic [XLEN-1:0] trap_pc
);

    logic            ext_pending;
    logic            timer_pending;
    logic [XLEN-1:0] base;
    logic [XLEN-1:0] offset;

    assign ext_pending   = meie & ext_irq;
    assign timer_pending = mtie & timer_irq;

    // MRET masks interrupts for its own cycle so the return completes first
    assign trap_taken = global_ie & (ext_pending | timer_pending) & ~is_mret;
    assign cause      = ext_pending ? CAUSE_MEI : CAUSE_MTI;

    // Vectored mode (mode bit 0) jumps to base + 4*cause
    assign base    = mtvec & ~XLEN'(3);
    assign offset  = mtvec[0] ? {{(XLEN-6){1'b0}}, cause, 2'b00} : '0;
    assign trap_pc = base + offset;

endmodule

// File: rtl/csr_unit.sv
// csr_unit
// Machine-mode CSR block accessed from the MW stage: Zicsr reads and
// write/set/clear updates, timer/external interrupt entry, MRET return,
// vectored mtvec and an optional 64-bit mcycle counter.
// Ports:
//   clk, reset   - core clock, asynchronous active-high reset
//   csr_op       - 00 none, 01 write, 10 set, 11 clear
//   csr_rd       - read enable for csr_rdata
//   csr_addr     - CSR address
//   csr_wdata    - rs1 / zimm operand
//   csr_pc       - PC of the MW instruction, saved to mepc on trap
//   timer_irq    - MTIP level
//   ext_irq      - MEIP level
//   is_mret      - MRET in MW this cycle
//   csr_rdata    - old value of the addressed CSR (0 when not reading)
//   csr_illegal  - access to an unimplemented CSR
//   trap_taken   - interrupt accepted, pipeline flushes and redirects
//   trap_pc      - redirect target
//   epc          - current mepc (MRET target)
module csr_unit
    import csr_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] MTVEC_RESET = 32'h0000_0000,
    parameter bit              CYCLE_EN    = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [1:0]      csr_op,
    input  logic            csr_rd,
    input  logic [11:0]     csr_addr,
    input  logic [XLEN-1:0] csr_wdata,
    input  logic [XLEN-1:0] csr_pc,
    input  logic            timer_irq,
    input  logic            ext_irq,
    input  logic            is_mret,
    output logic [XLEN-1:0] csr_rdata,
    output logic            csr_illegal,
    output logic            trap_taken,
    output logic [XLEN-1:0] trap_pc,
    output logic [XLEN-1:0] epc
);

    generate
        if (XLEN != 32) begin : g_xlen_check
            $error("csr_unit: only XLEN=32 is supported");
        end
    endgenerate

    logic            mstatus_mie;
    logic            mstatus_mpie;
    logic            mie_mtie;
    logic            mie_meie;
    logic [XLEN-1:0] mtvec;
    logic [XLEN-1:0] mepc;
    logic [XLEN-1:0] mcause;
    logic [63:0]     mcycle;

    csr_op_e         op;
    logic [XLEN-1:0] old_value;
    logic [XLEN-1:0] new_value;
    logic            implemented;
    logic            csr_we;
    logic [3:0]      cause;

    assign op = csr_op_e'(csr_op);

    // Read mux; unimplemented addresses read 0 and clear 'implemented'
    always_comb begin
        old_value   = '0;
        implemented = 1'b1;
        case (csr_addr)
            ADDR_MSTATUS: begin
                old_value[MSTATUS_MIE_BIT]       = mstatus_mie;
                old_value[MSTATUS_MPIE_BIT]      = mstatus_mpie;
                old_value[MSTATUS_MPP_LO +: 2]   = 2'b11;
            end
            ADDR_MIE: begin
                old_value[MIE_MTIE_BIT] = mie_mtie;
                old_value[MIE_MEIE_BIT] = mie_meie;
            end
            ADDR_MTVEC:  old_value = mtvec;
            ADDR_MEPC:   old_value = mepc;
            ADDR_MCAUSE: old_value = mcause;
            ADDR_MIP: begin
                old_value[MIP_MTIP_BIT] = timer_irq;
                old_value[MIP_MEIP_BIT] = ext_irq;
            end
            ADDR_MCYCLE: begin
                if (CYCLE_EN) old_value = mcycle[31:0];
                else          implemented = 1'b0;
            end
            ADDR_MCYCLEH: begin
                if (CYCLE_EN) old_value = mcycle[63:32];
                else          implemented = 1'b0;
            end
            default: implemented = 1'b0;
        endcase
    end

    // Zicsr read-modify-write operand
    always_comb begin
        new_value = old_value;
        case (op)
            CSR_WRITE: new_value = csr_wdata;
            CSR_SET:   new_value = old_value | csr_wdata;
            CSR_CLEAR: new_value = old_value & ~csr_wdata;
            default:   new_value = old_value;
        endcase
    end

    assign csr_rdata   = csr_rd ? old_value : '0;
    assign csr_illegal = ((op != CSR_NONE) | csr_rd) & ~implemented;

    // A trap or an MRET in the same cycle drops the CSR write
    assign csr_we = (op != CSR_NONE) & implemented & ~trap_taken & ~is_mret;

    csr_trap_ctrl #(
        .XLEN(XLEN)
    ) u_trap_ctrl (
        .global_ie  (mstatus_mie),
        .mtie       (mie_mtie),
        .meie       (mie_meie),
        .timer_irq  (timer_irq),
        .ext_irq    (ext_irq),
        .is_mret    (is_mret),
        .mtvec      (mtvec),
        .trap_taken (trap_taken),
        .cause      (cause),
        .trap_pc    (trap_pc)
    );

    assign epc = mepc;

    // Architected state: trap entry beats MRET, which beats a CSR write
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mstatus_mie  <= 1'b0;
            mstatus_mpie <= 1'b0;
            mie_mtie     <= 1'b0;
            mie_meie     <= 1'b0;
            mtvec        <= MTVEC_RESET;
            mepc         <= '0;
            mcause       <= '0;
        end else if (trap_taken) begin
            mepc         <= csr_pc & ~XLEN'(3);
            mcause       <= {1'b1, {(XLEN-5){1'b0}}, cause};
            mstatus_mpie <= mstatus_mie;
            mstatus_mie  <= 1'b0;
        end else if (is_mret) begin
            mstatus_mie  <= mstatus_mpie;
            mstatus_mpie <= 1'b1;
        end else if (csr_we) begin
            case (csr_addr)
                ADDR_MSTATUS: begin
                    mstatus_mie  <= new_value[MSTATUS_MIE_BIT];
                    mstatus_mpie <= new_value[MSTATUS_MPIE_BIT];
                end
                ADDR_MIE: begin
                    mie_mtie <= new_value[MIE_MTIE_BIT];
                    mie_meie <= new_value[MIE_MEIE_BIT];
                end
                // mode bit 1 is WARL-zero, leaving direct or vectored
                ADDR_MTVEC:  mtvec  <= new_value & ~XLEN'(2);
                ADDR_MEPC:   mepc   <= new_value & ~XLEN'(3);
                ADDR_MCAUSE: mcause <= new_value;
                default: ;
            endcase
        end
    end

    // Free-running cycle counter; a write replaces one half and
    // suppresses the increment for that cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcycle <= '0;
        end else if (CYCLE_EN) begin
            if (csr_we && csr_addr == ADDR_MCYCLE)
                mcycle <= {mcycle[63:32], new_value};
            else if (csr_we && csr_addr == ADDR_MCYCLEH)
                mcycle <= {new_value, mcycle[31:0]};
            else
                mcycle <= mcycle + 64'd1;
        end
    end

endmodule

// File: tb/tb_csr_unit.sv
// tb_csr_unit
// Directed testbench for csr_unit: reset values, Zicsr operations,
// direct and vectored trap entry, MRET, dropped writes and mcycle wrap.
module tb_csr_unit;

    logic        clk;
    logic        reset;
    logic [1:0]  csr_op;
    logic        csr_rd;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_pc;
    logic        timer_irq;
    logic        ext_irq;
    logic        is_mret;
    logic [31:0] csr_rdata;
    logic        csr_illegal;
    logic        trap_taken;
    logic [31:0] trap_pc;
    logic [31:0] epc;

    int checks = 0;
    int errors = 0;

    logic [31:0] rv;
    logic        ill;

    csr_unit #(
        .XLEN        (32),
        .MTVEC_RESET (32'h0000_0000),
        .CYCLE_EN    (1'b1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .csr_op      (csr_op),
        .csr_rd      (csr_rd),
        .csr_addr    (csr_addr),
        .csr_wdata   (csr_wdata),
        .csr_pc      (csr_pc),
        .timer_irq   (timer_irq),
        .ext_irq     (ext_irq),
        .is_mret     (is_mret),
        .csr_rdata   (csr_rdata),
        .csr_illegal (csr_illegal),
        .trap_taken  (trap_taken),
        .trap_pc     (trap_pc),
        .epc         (epc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational read: takes 1ns, never straddles a clock edge when
    // called right after a posedge+1 or at a negedge
    task automatic read_csr(input logic [11:0] addr, output logic [31:0] data,
                            output logic illegal);
        csr_rd   = 1'b1;
        csr_addr = addr;
        #1;
        data    = csr_rdata;
        illegal = csr_illegal;
        csr_rd  = 1'b0;
    endtask

    // One CSR instruction through MW, committed at the next posedge
    task automatic do_write(input logic [1:0] op, input logic [11:0] addr,
                            input logic [31:0] data);
        @(negedge clk);
        csr_op    = op;
        csr_addr  = addr;
        csr_wdata = data;
        @(posedge clk);
        #1;
        csr_op = 2'b00;
    endtask

    task automatic test_reset;
        logic [11:0] addrs [8];
        logic [31:0] exp   [8];
        addrs = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342, 12'h344, 12'hB00, 12'hB80};
        exp   = '{32'h1800, 32'h0, 32'h0, 32'h0, 32'h0, 32'h80, 32'h0, 32'h0};
        reset     = 1'b1;
        timer_irq = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            read_csr(addrs[i], rv, ill);
            checks++;
            if (rv !== exp[i] || ill !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_read addr=%h: got %h ill=%b, expected %h ill=0",
                         addrs[i], rv, ill, exp[i]);
            end
        end
        read_csr(12'h7C0, rv, ill);
        checks++;
        if (rv !== 32'h0 || ill !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_unimpl: got %h ill=%b, expected 0 ill=1", rv, ill);
        end
        checks++;
        if (trap_taken !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_no_trap: got %b, expected 0", trap_taken);
        end
        timer_irq = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_write_ops;
        do_write(2'b01, 12'h304, 32'hFFFF_FFFF);
        read_csr(12'h304, rv, ill);
        checks++;
        if (rv !== 32'h0000_0880) begin
            errors++;
            $display("[TB] FAIL csrrw_mie: got %h, expected 00000880", rv);
        end
        do_write(2'b10, 12'h300, 32'h8);
        read_csr(12'h300, rv, ill);
        checks++;
        if (rv !== 32'h0000_1808) begin
            errors++;
            $display("[TB] FAIL csrrs_mstatus: got %h, expected 00001808", rv);
        end
        do_write(2'b11, 12'h300, 32'h8);
        read_csr(12'h300, rv, ill);
        checks++;
        if (rv !== 32'h0000_1800) begin
            errors++;
            $display("[TB] FAIL csrrc_mstatus: got %h, expected 00001800", rv);
        end
        do_write(2'b01, 12'h341, 32'h0000_0043);
        read_csr(12'h341, rv, ill);
        checks++;
        if (rv !== 32'h0000_0040 || epc !== 32'h0000_0040) begin
            errors++;
            $display("[TB] FAIL mepc_align: got %h epc=%h, expected 00000040", rv, epc);
        end
        do_write(2'b01, 12'h305, 32'h0000_0103);
        read_csr(12'h305, rv, ill);
        checks++;
        if (rv !== 32'h0000_0101) begin
            errors++;
            $display("[TB] FAIL mtvec_warl: got %h, expected 00000101", rv);
        end
        do_write(2'b01, 12'h342, 32'hDEAD_BEEF);
        read_csr(12'h342, rv, ill);
        checks++;
        if (rv !== 32'hDEAD_BEEF) begin
            errors++;
            $display("[TB] FAIL mcause_rw: got %h, expected deadbeef", rv);
        end
        // mip write: ignored, not illegal
        @(negedge clk);
        csr_op    = 2'b01;
        csr_addr  = 12'h344;
        csr_wdata = 32'hFFFF_FFFF;
        #1;
        checks++;
        if (csr_illegal !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mip_write_legal: got %b, expected 0", csr_illegal);
        end
        @(posedge clk);
        #1;
        csr_op = 2'b00;
        read_csr(12'h344, rv, ill);
        checks++;
        if (rv !== 32'h0) begin
            errors++;
            $display("[TB] FAIL mip_readonly: got %h, expected 0", rv);
        end
        // read enable low gives 0; write to unimplemented flagged
        @(negedge clk);
        csr_addr  = 12'h300;
        csr_rd    = 1'b0;
        #1;
        checks++;
        if (csr_rdata !== 32'h0) begin
            errors++;
            $display("[TB] FAIL rd_gate: got %h, expected 0", csr_rdata);
        end
        csr_op   = 2'b01;
        csr_addr = 12'h7C0;
        #1;
        checks++;
        if (csr_illegal !== 1'b1) begin
            errors++;
            $display("[TB] FAIL unimpl_write: got %b, expected 1", csr_illegal);
        end
        csr_op = 2'b00;
    endtask

    task automatic test_trap_direct;
        do_write(2'b01, 12'h305, 32'h0000_0100);
        do_write(2'b01, 12'h304, 32'h0000_0080);
        do_write(2'b10, 12'h300, 32'h0000_0008);
        @(negedge clk);
        csr_pc    = 32'h0000_0040;
        timer_irq = 1'b1;
        csr_op    = 2'b01;
        csr_addr  = 12'h304;
        csr_wdata = 32'h0;
        #1;
        checks++;
        if (trap_taken !== 1'b1 || trap_pc !== 32'h0000_0100) begin
            errors++;
            $display("[TB] FAIL direct_trap: got taken=%b pc=%h, expected 1 00000100",
                     trap_taken, trap_pc);
        end
        @(posedge clk);
        #1;
        csr_op = 2'b00;
        checks++;
        if (trap_taken !== 1'b0) begin
            errors++;
            $display("[TB] FAIL masked_after_trap: got %b, expected 0", trap_taken);
        end
        checks++;
        if (epc !== 32'h0000_0040) begin
            errors++;
            $display("[TB] FAIL trap_mepc: got %h, expected 00000040", epc);
        end
        read_csr(12'h342, rv, ill);
        checks++;
        if (rv !== 32'h8000_0007) begin
            errors++;
            $display("[TB] FAIL trap_mcause: got %h, expected 80000007", rv);
        end
        read_csr(12'h300, rv, ill);
        checks++;
        if (rv !== 32'h0000_1880) begin
            errors++;
            $display("[TB] FAIL trap_mstatus: got %h, expected 00001880", rv);
        end
        read_csr(12'h304, rv, ill);
        checks++;
        if (rv !== 32'h0000_0080) begin
            errors++;
            $display("[TB] FAIL trap_drops_write: got %h, expected 00000080", rv);
        end
    endtask

    task automatic test_mret;
        // timer_irq still high; MRET restores MIE
        @(negedge clk);
        is_mret = 1'b1;
        #1;
        checks++;
        if (epc !== 32'h0000_0040 || trap_taken !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mret_cycle: got epc=%h taken=%b, expected 00000040 0",
                     epc, trap_taken);
        end
        @(posedge clk);
        #1;
        is_mret = 1'b0;
        read_csr(12'h300, rv, ill);
        checks++;
        if (rv !== 32'h0000_1888) begin
            errors++;
            $display("[TB] FAIL mret_mstatus: got %h, expected 00001888", rv);
        end
        checks++;
        if (trap_taken !== 1'b1) begin
            errors++;
            $display("[TB] FAIL trap_after_mret: got %b, expected 1", trap_taken);
        end
        // MRET with MIE=1 and irq pending: masked, and a CSR write is dropped
        @(negedge clk);
        is_mret   = 1'b1;
        csr_op    = 2'b01;
        csr_addr  = 12'h342;
        csr_wdata = 32'h0000_1234;
        #1;
        checks++;
        if (trap_taken !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mret_masks: got %b, expected 0", trap_taken);
        end
        @(posedge clk);
        #1;
        is_mret   = 1'b0;
        csr_op    = 2'b00;
        timer_irq = 1'b0;
        read_csr(12'h342, rv, ill);
        checks++;
        if (rv !== 32'h8000_0007) begin
            errors++;
            $display("[TB] FAIL mret_drops_write: got %h, expected 80000007", rv);
        end
    endtask

    task automatic test_trap_vectored;
        do_write(2'b01, 12'h305, 32'h0000_0101);
        do_write(2'b01, 12'h304, 32'h0000_0880);
        @(negedge clk);
        csr_pc    = 32'h0000_0086;
        timer_irq = 1'b1;
        ext_irq   = 1'b1;
        #1;
        checks++;
        if (trap_taken !== 1'b1 || trap_pc !== 32'h0000_012C) begin
            errors++;
            $display("[TB] FAIL vectored_ext: got taken=%b pc=%h, expected 1 0000012c",
                     trap_taken, trap_pc);
        end
        @(posedge clk);
        #1;
        timer_irq = 1'b0;
        ext_irq   = 1'b0;
        read_csr(12'h342, rv, ill);
        checks++;
        if (rv !== 32'h8000_000B || epc !== 32'h0000_0084) begin
            errors++;
            $display("[TB] FAIL vectored_state: got mcause=%h epc=%h, expected 8000000b 00000084",
                     rv, epc);
        end
        do_write(2'b10, 12'h300, 32'h0000_0008);
        @(negedge clk);
        timer_irq = 1'b1;
        #1;
        checks++;
        if (trap_taken !== 1'b1 || trap_pc !== 32'h0000_011C) begin
            errors++;
            $display("[TB] FAIL vectored_timer: got taken=%b pc=%h, expected 1 0000011c",
                     trap_taken, trap_pc);
        end
        @(posedge clk);
        #1;
        timer_irq = 1'b0;
        read_csr(12'h342, rv, ill);
        checks++;
        if (rv !== 32'h8000_0007) begin
            errors++;
            $display("[TB] FAIL vectored_timer_cause: got %h, expected 80000007", rv);
        end
    endtask

    task automatic test_mcycle;
        logic [31:0] hi;
        do_write(2'b01, 12'hB80, 32'hFFFF_FFFF);
        do_write(2'b01, 12'hB00, 32'hFFFF_FFFE);
        read_csr(12'hB00, rv, ill);
        read_csr(12'hB80, hi, ill);
        checks++;
        if (rv !== 32'hFFFF_FFFE || hi !== 32'hFFFF_FFFF) begin
            errors++;
            $display("[TB] FAIL mcycle_write: got %h_%h, expected ffffffff_fffffffe", hi, rv);
        end
        repeat (2) @(posedge clk);
        #1;
        read_csr(12'hB00, rv, ill);
        read_csr(12'hB80, hi, ill);
        checks++;
        if (rv !== 32'h0 || hi !== 32'h0) begin
            errors++;
            $display("[TB] FAIL mcycle_wrap: got %h_%h, expected 0_0", hi, rv);
        end
        @(posedge clk);
        #1;
        read_csr(12'hB00, rv, ill);
        checks++;
        if (rv !== 32'h1) begin
            errors++;
            $display("[TB] FAIL mcycle_inc: got %h, expected 1", rv);
        end
        repeat (5) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        read_csr(12'hB00, rv, ill);
        read_csr(12'hB80, hi, ill);
        checks++;
        if (rv !== 32'h0 || hi !== 32'h0) begin
            errors++;
            $display("[TB] FAIL async_reset_mcycle: got %h_%h, expected 0_0", hi, rv);
        end
        read_csr(12'h305, rv, ill);
        checks++;
        if (rv !== 32'h0 || epc !== 32'h0) begin
            errors++;
            $display("[TB] FAIL async_reset_state: got mtvec=%h epc=%h, expected 0 0", rv, epc);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        csr_op    = 2'b00;
        csr_rd    = 1'b0;
        csr_addr  = 12'h0;
        csr_wdata = 32'h0;
        csr_pc    = 32'h0;
        timer_irq = 1'b0;
        ext_irq   = 1'b0;
        is_mret   = 1'b0;

        test_reset();
        test_write_ops();
        test_trap_direct();
        test_mret();
        test_trap_vectored();
        test_mcycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
